// File: rtl/bp_pkg.sv
// bp_pkg
// Shared types and helpers for the branch direction predictor.
//   ctr_t      : 2-bit saturating direction counter (MSB = predict taken)
//   CTR_RESET  : reset value of every counter (weakly not-taken)
//   ctrUpdate  : saturating train of one counter toward the actual outcome
//   redirect_t : registered mispredict redirect {valid, pc}
package bp_pkg;

   typedef logic [1:0] ctr_t;

   localparam ctr_t CTR_RESET = 2'b01;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
   } redirect_t;

   // Move the counter one step toward the outcome, sticking at the rails.
   function automatic ctr_t ctrUpdate(input ctr_t c, input logic taken);
      if (taken) begin
         return (c == 2'b11) ? c : c + 2'd1;
      end else begin
         return (c == 2'b00) ? c : c - 2'd1;
      end
   endfunction

endpackage

// File: rtl/branch_predict_resolve_if.sv
// branch_predict_resolve_if
// Bundles the fetch-side lookup, the EX-side resolve and the redirect
// outputs of the predictor.
//   master : pipeline side (drives q_*, ex_* requests; receives predictions)
//   slave  : predictor side
// Parameter IDX_W must equal log2 of the predictor's table depth.
interface branch_predict_resolve_if #(
   parameter int IDX_W = 6
);
   // Fetch lookup
   logic             q_valid;
   logic             q_stall;
   logic [31:0]      q_pc;
   logic             q_pred_taken;
   logic [IDX_W-1:0] q_idx;
   // EX resolve
   logic             ex_valid;
   logic             ex_is_branch;
   logic             ex_taken;
   logic             ex_pred_taken;
   logic [IDX_W-1:0] ex_idx;
   logic [31:0]      ex_pc;
   logic [31:0]      ex_target;
   // Redirect
   logic             redirect_valid;
   logic [31:0]      redirect_pc;
   logic             flush;

   modport master (
      output q_valid, q_stall, q_pc,
      output ex_valid, ex_is_branch, ex_taken, ex_pred_taken, ex_idx, ex_pc, ex_target,
      input  q_pred_taken, q_idx, redirect_valid, redirect_pc, flush
   );

   modport slave (
      input  q_valid, q_stall, q_pc,
      input  ex_valid, ex_is_branch, ex_taken, ex_pred_taken, ex_idx, ex_pc, ex_target,
      output q_pred_taken, q_idx, redirect_valid, redirect_pc, flush
   );
endinterface

// File: rtl/bp_counter_table.sv
// bp_counter_table
// Table of 2-bit saturating counters with one training write port and one
// combinational read port. A read of the index being written this cycle
// returns the post-update MSB, so a lookup never sees a stale counter.
//   clk, rst_n : clock, asynchronous active-low reset (all counters -> 01)
//   wrEn       : train entry wrIdx toward direction wrDir at this edge
//   rdIdx      : lookup index
//   rdMsb      : predicted direction for rdIdx (bypassed)
module bp_counter_table
   import bp_pkg::*;
#(
   parameter int ENTRIES = 64,
   parameter int IDX_W   = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wrEn,
   input  logic [IDX_W-1:0] wrIdx,
   input  logic             wrDir,
   input  logic [IDX_W-1:0] rdIdx,
   output logic             rdMsb
);

   ctr_t ctrMem [ENTRIES];
   ctr_t rdCtr;
   ctr_t rdNext;

   // Counters need a defined reset value, so the table is register-based.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            ctrMem[i] <= CTR_RESET;
         end
      end else if (wrEn) begin
         ctrMem[wrIdx] <= ctrUpdate(ctrMem[wrIdx], wrDir);
      end
   end

   always_comb begin
      rdCtr  = ctrMem[rdIdx];
      rdNext = ctrUpdate(rdCtr, wrDir);
      rdMsb  = (wrEn && (wrIdx == rdIdx)) ? rdNext[1] : rdCtr[1];
   end

endmodule

// File: rtl/branch_predict_resolve.sv
// branch_predict_resolve
// Dynamic branch direction predictor and resolution unit. Looks up a 2-bit
// counter from the fetch PC and registers the prediction for ID; trains the
// table from EX outcomes one cycle after resolve and raises a one-cycle
// redirect/flush on a direction mispredict.
//   clk, rst_n : clock, asynchronous active-low reset
//   bp         : slave side of branch_predict_resolve_if (lookup, resolve,
//                redirect_valid / redirect_pc / flush)
// Optional feature: define BP_GSHARE_EN to XOR the lookup index with an
// IDX_W-bit global history of resolved branch outcomes.
module branch_predict_resolve
   import bp_pkg::*;
#(
   parameter int  BHT_ENTRIES = 64,
   localparam int IDX_W       = $clog2(BHT_ENTRIES)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   branch_predict_resolve_if.slave   bp
);

   logic             resolve;
   logic             mispredict;
   logic [IDX_W-1:0] lookupIdx;
   logic             lookupMsb;

   logic             pendValid;
   logic [IDX_W-1:0] pendIdx;
   logic             pendDir;

   logic             qPredReg;
   logic [IDX_W-1:0] qIdxReg;
   redirect_t        redirectReg;

   assign resolve    = bp.ex_valid && bp.ex_is_branch;
   assign mispredict = bp.ex_taken != bp.ex_pred_taken;

`ifdef BP_GSHARE_EN
   // History is non-speculative: it only advances on resolved branches.
   logic [IDX_W-1:0] ghr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ghr <= '0;
      end else if (resolve) begin
         ghr <= {ghr[IDX_W-2:0], bp.ex_taken};
      end
   end

   assign lookupIdx = bp.q_pc[IDX_W+1:2] ^ ghr;
`else
   assign lookupIdx = bp.q_pc[IDX_W+1:2];
`endif

   bp_counter_table #(
      .ENTRIES (BHT_ENTRIES),
      .IDX_W   (IDX_W)
   ) uTable (
      .clk   (clk),
      .rst_n (rst_n),
      .wrEn  (pendValid),
      .wrIdx (pendIdx),
      .wrDir (pendDir),
      .rdIdx (lookupIdx),
      .rdMsb (lookupMsb)
   );

   // Lookup registers: stall holds both; an idle slot clears the prediction
   // but keeps the last index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         qPredReg <= 1'b0;
         qIdxReg  <= '0;
      end else if (!bp.q_stall) begin
         if (bp.q_valid) begin
            qPredReg <= lookupMsb;
            qIdxReg  <= lookupIdx;
         end else begin
            qPredReg <= 1'b0;
         end
      end
   end

   // Training is deferred one cycle; the table bypass covers the gap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pendValid <= 1'b0;
         pendIdx   <= '0;
         pendDir   <= 1'b0;
      end else begin
         pendValid <= resolve;
         if (resolve) begin
            pendIdx <= bp.ex_idx;
            pendDir <= bp.ex_taken;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         redirectReg <= '0;
      end else begin
         redirectReg.valid <= resolve && mispredict;
         if (resolve && mispredict) begin
            redirectReg.pc <= bp.ex_taken ? bp.ex_target : bp.ex_pc + 32'd4;
         end
      end
   end

   assign bp.q_pred_taken   = qPredReg;
   assign bp.q_idx          = qIdxReg;
   assign bp.redirect_valid = redirectReg.valid;
   assign bp.redirect_pc    = redirectReg.pc;
   assign bp.flush          = redirectReg.valid;

endmodule

// File: tb/tb_branch_predict_resolve.sv
// tb_branch_predict_resolve
// Directed scenarios followed by randomized lookup/resolve traffic, checked
// against an abstract model: a counter array in which a resolved branch
// becomes visible to lookups registered on any later edge, plus the expected
// registered outputs.
module tb_branch_predict_resolve;

   localparam int BHT   = 64;
   localparam int IDX_W = 6;

   logic clk;
   logic rst_n;

   branch_predict_resolve_if #(.IDX_W(IDX_W)) bpIf ();

   branch_predict_resolve #(.BHT_ENTRIES(BHT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bp    (bpIf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checkCount = 0;
   int passCount  = 0;

   // Reference state
   int          ctr [BHT];
   int          ghr;
   logic        expPred;
   int          expIdx;
   logic        expRv;
   logic [31:0] expRpc;

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      if (obs === exp) begin
         passCount++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic resetModel();
      for (int i = 0; i < BHT; i++) ctr[i] = 1;
      ghr     = 0;
      expPred = 1'b0;
      expIdx  = 0;
      expRv   = 1'b0;
      expRpc  = 32'h0;
   endtask

   // One rising edge of the abstract machine.
   task automatic modelEdge();
      int idx;
      idx = (bpIf.q_pc >> 2) % BHT;
`ifdef BP_GSHARE_EN
      idx = idx ^ ghr;
`endif
      if (!bpIf.q_stall) begin
         if (bpIf.q_valid) begin
            expIdx  = idx;
            expPred = (ctr[idx] >= 2);
         end else begin
            expPred = 1'b0;
         end
      end
      if (bpIf.ex_valid && bpIf.ex_is_branch) begin
         if (bpIf.ex_taken != bpIf.ex_pred_taken) begin
            expRv  = 1'b1;
            expRpc = bpIf.ex_taken ? bpIf.ex_target : bpIf.ex_pc + 32'd4;
         end else begin
            expRv = 1'b0;
         end
         if (bpIf.ex_taken) ctr[bpIf.ex_idx] = (ctr[bpIf.ex_idx] == 3) ? 3 : ctr[bpIf.ex_idx] + 1;
         else               ctr[bpIf.ex_idx] = (ctr[bpIf.ex_idx] == 0) ? 0 : ctr[bpIf.ex_idx] - 1;
         ghr = ((ghr << 1) | int'(bpIf.ex_taken)) % BHT;
      end else begin
         expRv = 1'b0;
      end
   endtask

   task automatic checkOutputs();
      checkVal("q_pred_taken", {31'b0, bpIf.q_pred_taken}, {31'b0, expPred});
      checkVal("q_idx", {26'b0, bpIf.q_idx}, expIdx);
      checkVal("redirect_valid", {31'b0, bpIf.redirect_valid}, {31'b0, expRv});
      checkVal("flush", {31'b0, bpIf.flush}, {31'b0, expRv});
      if (expRv) checkVal("redirect_pc", bpIf.redirect_pc, expRpc);
   endtask

   task automatic cycle();
      @(posedge clk);
      if (!rst_n) resetModel();
      else        modelEdge();
      #1;
      checkOutputs();
   endtask

   task automatic idleInputs();
      bpIf.q_valid       = 1'b0;
      bpIf.q_stall       = 1'b0;
      bpIf.q_pc          = 32'h0;
      bpIf.ex_valid      = 1'b0;
      bpIf.ex_is_branch  = 1'b0;
      bpIf.ex_taken      = 1'b0;
      bpIf.ex_pred_taken = 1'b0;
      bpIf.ex_idx        = '0;
      bpIf.ex_pc         = 32'h0;
      bpIf.ex_target     = 32'h0;
   endtask

   task automatic lookup(input logic [31:0] pc);
      bpIf.q_valid = 1'b1;
      bpIf.q_pc    = pc;
   endtask

   task automatic resolveBr(input int idx, input logic taken, input logic pred,
                            input logic [31:0] pc, input logic [31:0] target);
      bpIf.ex_valid      = 1'b1;
      bpIf.ex_is_branch  = 1'b1;
      bpIf.ex_taken      = taken;
      bpIf.ex_pred_taken = pred;
      bpIf.ex_idx        = IDX_W'(idx);
      bpIf.ex_pc         = pc;
      bpIf.ex_target     = target;
   endtask

   initial begin
      idleInputs();
      rst_n = 1'b0;
      resetModel();
      #2;
      checkVal("rst_pred", {31'b0, bpIf.q_pred_taken}, 32'd0);
      checkVal("rst_idx", {26'b0, bpIf.q_idx}, 32'd0);
      checkVal("rst_redirect", {31'b0, bpIf.redirect_valid}, 32'd0);
      checkVal("rst_redirect_pc", bpIf.redirect_pc, 32'd0);
      cycle();
      cycle();
      rst_n = 1'b1;

      // Lookup 0x100 after reset
      lookup(32'h100);
      cycle();
      checkVal("tp_lookup_pred", {31'b0, bpIf.q_pred_taken}, 32'd0);
      checkVal("tp_lookup_idx", {26'b0, bpIf.q_idx}, 32'd0);
      idleInputs();

      // Taken mispredict at 0x100 -> target 0x80
      resolveBr(0, 1'b1, 1'b0, 32'h100, 32'h80);
      cycle();
      checkVal("tp_taken_rv", {31'b0, bpIf.redirect_valid}, 32'd1);
      checkVal("tp_taken_rpc", bpIf.redirect_pc, 32'h80);
      idleInputs();
      lookup(32'h100);
      cycle();
      checkVal("tp_rv_pulse", {31'b0, bpIf.redirect_valid}, 32'd0);
`ifndef BP_GSHARE_EN
      checkVal("tp_trained_pred", {31'b0, bpIf.q_pred_taken}, 32'd1);
`endif
      idleInputs();

      // Not-taken mispredicts: fall-through and 32-bit wrap
      resolveBr(0, 1'b0, 1'b1, 32'h200, 32'h40);
      cycle();
      checkVal("tp_nt_rpc", bpIf.redirect_pc, 32'h204);
      resolveBr(0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h40);
      cycle();
      checkVal("tp_wrap_rpc", bpIf.redirect_pc, 32'h0);
      checkVal("tp_wrap_rv", {31'b0, bpIf.redirect_valid}, 32'd1);
      idleInputs();

      // Saturation on index 7: four taken, one not-taken
      for (int i = 0; i < 4; i++) begin
         resolveBr(7, 1'b1, 1'b1, 32'h1C, 32'h300);
         cycle();
      end
      resolveBr(7, 1'b0, 1'b1, 32'h1C, 32'h300);
      cycle();
      idleInputs();
      lookup(32'h1C);
      cycle();
`ifndef BP_GSHARE_EN
      checkVal("tp_sat_pred", {31'b0, bpIf.q_pred_taken}, 32'd1);
`endif
      idleInputs();

      // Bypass: resolve index 5, look it up on the very next cycle
      resolveBr(5, 1'b1, 1'b1, 32'h14, 32'h500);
      cycle();
      idleInputs();
      lookup(32'h14);
      cycle();
`ifndef BP_GSHARE_EN
      checkVal("tp_bypass_pred", {31'b0, bpIf.q_pred_taken}, 32'd1);
`endif
      idleInputs();

      // Stall holds, non-branch does nothing
      lookup(32'h1C);
      bpIf.q_stall = 1'b1;
      bpIf.ex_valid = 1'b1;
      cycle();
      idleInputs();

      // Reset while a mispredict is about to be registered
      resolveBr(9, 1'b1, 1'b0, 32'h24, 32'h900);
      rst_n = 1'b0;
      #1;
      resetModel();
      checkOutputs();
      cycle();
      idleInputs();
      rst_n = 1'b1;
      cycle();
      checkVal("tp_rst_no_redirect", {31'b0, bpIf.redirect_valid}, 32'd0);
      for (int i = 0; i < BHT; i++) begin
         lookup(32'(i) << 2);
         cycle();
      end
      idleInputs();

      // History: two taken resolves then lookup 0x100
      resolveBr(1, 1'b1, 1'b1, 32'h4, 32'h40);
      cycle();
      cycle();
      idleInputs();
      lookup(32'h100);
      cycle();
`ifdef BP_GSHARE_EN
      checkVal("tp_gshare_idx", {26'b0, bpIf.q_idx}, 32'h3);
`else
      checkVal("tp_plain_idx", {26'b0, bpIf.q_idx}, 32'h0);
`endif
      idleInputs();

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         bpIf.q_valid       = ($urandom_range(0, 3) != 0);
         bpIf.q_stall       = ($urandom_range(0, 4) == 0);
         bpIf.q_pc          = $urandom_range(0, 255) << 2;
         bpIf.ex_valid      = ($urandom_range(0, 1) == 1);
         bpIf.ex_is_branch  = ($urandom_range(0, 3) != 0);
         bpIf.ex_taken      = 1'($urandom_range(0, 1));
         bpIf.ex_pred_taken = 1'($urandom_range(0, 1));
         bpIf.ex_idx        = IDX_W'($urandom_range(0, 15));
         bpIf.ex_pc         = $urandom & 32'hFFFF_FFFC;
         bpIf.ex_target     = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
         cycle();
         rst_n = 1'b1;
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/branch_predict_resolve.md
# branch_predict_resolve

Dynamic branch direction predictor and resolution unit for the 5-stage RISC-V pipeline. Holds a table of 2-bit saturating counters indexed from the fetch PC and returns a registered prediction aligned with ID. Consumes the EX-stage branch outcome (`taken` from the branch evaluator) and trains the table. On a direction mispredict it issues a one-cycle redirect and flush to IF/ID.

## Interface
- `BHT_ENTRIES`, 64: counter table depth; power of two, 4..1024.
- `IDX_W`, log2(`BHT_ENTRIES`): index width; derived, not overridden.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `q_valid` in 1: fetch-side lookup request.
- `q_stall` in 1: hold registered prediction outputs; IF/ID stalled.
- `q_pc` in 32: fetch PC.
- `q_pred_taken` out 1: registered predicted direction, valid in ID.
- `q_idx` out `IDX_W`: registered table index used; carried down pipeline to EX.
- `ex_valid` in 1: resolving instruction in EX; high exactly one cycle per instruction.
- `ex_is_branch` in 1: instruction is a conditional branch.
- `ex_taken` in 1: actual outcome from branch evaluator.
- `ex_pred_taken` in 1: prediction carried from ID.
- `ex_idx` in `IDX_W`: index carried from ID.
- `ex_pc` in 32: branch PC.
- `ex_target` in 32: computed branch target.
- `redirect_valid` out 1: one-cycle mispredict pulse.
- `redirect_pc` out 32: correct next PC.
- `flush` out 1: equals `redirect_valid`; kills IF/ID/EX-next.

## Operation
- Index: `q_pc[IDX_W+1:2]`. With gshare enabled, XOR with GHR (see Configuration).
- Lookup: when `q_valid && !q_stall`, register `q_idx` = index and `q_pred_taken` = counter[index][1]. When `q_stall`, both hold. When `!q_valid && !q_stall`, `q_pred_taken` <= 0; `q_idx` holds.
- Resolve (`ex_valid && ex_is_branch`):
  - mispredict = `ex_taken != ex_pred_taken`.
  - Register update pending: {idx=`ex_idx`, dir=`ex_taken`}.
  - If mispredict, register `redirect_valid`=1, `redirect_pc` = `ex_taken` ? `ex_target` : `ex_pc`+4 (32-bit wrap).
- `ex_valid && !ex_is_branch`: no update, no redirect.
- Update stage (cycle after resolve): counter saturates at 2'b11 when taken and 2'b00 when not-taken; otherwise ±1.
- Bypass: a lookup in the same cycle as a pending write to the same index returns the post-update MSB.
- One resolve per cycle; back-to-back resolves to the same index chain correctly via the bypass of the pending write.

## Timing
- Reset (async assert, sync-to-clk deassert by system):
  - every counter = 2'b01 (weakly not-taken)
  - `q_pred_taken`=0, `q_idx`=0, `redirect_valid`=0, `flush`=0, `redirect_pc`=0
  - pending update cleared; GHR=0
- Lookup latency: 1 cycle (`q_pc` at edge N, prediction after edge N+1).
- Resolve-to-redirect: 1 cycle. `redirect_valid` is high for exactly one cycle, then returns to 0 unless the next cycle also mispredicts.
- Resolve-to-table-visible: counter updated at edge N+2; lookups at edge N+1 see it via bypass.
- Reset mid-operation: pending update and redirect are discarded; no partial write.
- `q_stall` does not block resolve or update.

## Configuration
- `BP_GSHARE_EN` defined:
  - `IDX_W`-bit global history register, shifted left with `ex_taken` on each resolved branch (non-speculative, updated at resolve edge).
  - Lookup index = PC bits XOR GHR.
  - `q_idx` carries the XORed index so training hits the same entry.
- Undefined: no GHR; index is PC bits only; GHR logic absent.

## Structure
- Shared package `bp_pkg`:
  - 2-bit counter typedef
  - `CTR_RESET` = 2'b01
  - saturating increment/decrement function
  - redirect struct {valid, pc}
- One sub-module `bp_counter_table`: counter array, async reset, one write port, one read port, same-index write bypass.
- The top level holds the lookup registers, resolve/redirect registers and GHR.

## Test plan
- Reset, then lookup PC 0x100 -> `q_pred_taken`=0, `q_idx`=0x00 one cycle later; `redirect_valid`=0.
- Resolve a taken branch at PC 0x100 (pred 0), target 0x80 -> next cycle `redirect_valid`=1, `redirect_pc`=0x80; counter goes 01->10; a later lookup of 0x100 predicts 1.
- Resolve a not-taken branch at PC 0x200 (pred 1) -> `redirect_pc`=0x204. With PC 0xFFFFFFFC -> `redirect_pc`=0x00000000.
- Four taken resolves on one index -> counter sticks at 11; one not-taken -> 10, prediction still 1.
- Resolve index 5 and look up index 5 in the next cycle -> lookup returns the post-update direction (bypass).
- `BP_GSHARE_EN`: resolve T,T, then look up PC 0x100 -> `q_idx` = 0x00 XOR 0b000011 = 0x03.
- Assert `rst_n` low for one cycle while a redirect is pending -> no redirect pulse; all counters read 01.
